// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared defaults and encodings for the memory controller:
//               word/address widths, implemented depth, FSM state enum and
//               the port-select encoding used by the arbiter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 9;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_LS = 1'b1
  } port_sel_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Two-port arbiter between instruction fetch and load/store.
//               A lone request wins outright; under contention the port not
//               granted last wins. The last-grant flop resets to the fetch
//               port so the first contended grant goes to load/store.
// Ports       : clk, rst_n        - clock, async active-low reset
//               arb_en            - controller is able to accept a grant
//               if_req, ls_req    - port requests
//               gnt_valid         - a grant is made this cycle
//               gnt_sel           - granted port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      arb_en,
  input  logic      if_req,
  input  logic      ls_req,
  output logic      gnt_valid,
  output port_sel_e gnt_sel
);

  port_sel_e last_q;
  port_sel_e last_d;

  always_comb begin
    gnt_valid = arb_en & (if_req | ls_req);
    gnt_sel   = SEL_LS;
    if (if_req && ls_req) begin
      gnt_sel = (last_q == SEL_LS) ? SEL_IF : SEL_LS;
    end else if (if_req) begin
      gnt_sel = SEL_IF;
    end
    last_d = last_q;
    if (gnt_valid) begin
      last_d = gnt_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SEL_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Single-channel memory controller serving an instruction-fetch
//               port and a load/store port against a synchronous memory with
//               one-cycle read latency. All outputs are registered.
// Ports       : clk, rst_n                          - clock, async active-low reset
//               if_req, if_addr, if_ack             - fetch handshake
//               ls_req, ls_we, ls_addr, ls_wdata,
//               ls_ack                              - load/store handshake
//               rdata, err                          - read data, out-of-range flag
//               mem_rw, mem_addr, mem_din, mem_dout - memory command/data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_e        state_q,    state_d;
  port_sel_e     sel_q,      sel_d;
  logic          mem_rw_q,   mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q,  mem_din_d;
  logic [DW-1:0] rdata_q,    rdata_d;
  logic          if_ack_q,   if_ack_d;
  logic          ls_ack_q,   ls_ack_d;
  logic          err_q,      err_d;

  logic          w_arb_en;
  logic          w_gnt_valid;
  port_sel_e     w_gnt_sel;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_din;
  logic          w_gnt_we;
  logic          w_gnt_oor;

  // Requests are only looked at while idle; in-flight accesses run on the
  // values captured at the grant edge.
  assign w_arb_en = (state_q == ST_IDLE);

  mem_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (w_arb_en),
    .if_req    (if_req),
    .ls_req    (ls_req),
    .gnt_valid (w_gnt_valid),
    .gnt_sel   (w_gnt_sel)
  );

  assign w_gnt_addr = (w_gnt_sel == SEL_LS) ? ls_addr  : if_addr;
  assign w_gnt_din  = (w_gnt_sel == SEL_LS) ? ls_wdata : '0;
  assign w_gnt_we   = (w_gnt_sel == SEL_LS) & ls_we;
  // One extra bit so a depth equal to 2**AW still compares correctly.
  assign w_gnt_oor  = ({1'b0, w_gnt_addr} >= (AW+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mem_rw_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    if_ack_d   = 1'b0;
    ls_ack_d   = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          sel_d      = w_gnt_sel;
          mem_addr_d = w_gnt_addr;
          mem_din_d  = w_gnt_din;
          if (w_gnt_oor) begin
            // Rejected access: ack straight away, memory never commanded.
            state_d  = ST_ACK;
            err_d    = 1'b1;
            rdata_d  = '0;
            if_ack_d = (w_gnt_sel == SEL_IF);
            ls_ack_d = (w_gnt_sel == SEL_LS);
          end else begin
            state_d  = ST_ISSUE;
            mem_rw_d = w_gnt_we;
          end
        end
      end
      ST_ISSUE: begin
        // mem_rw_q still carries the command of this issue cycle.
        if (mem_rw_q) begin
          state_d  = ST_ACK;
          if_ack_d = (sel_q == SEL_IF);
          ls_ack_d = (sel_q == SEL_LS);
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d  = ST_ACK;
        rdata_d  = mem_dout;
        if_ack_d = (sel_q == SEL_IF);
        ls_ack_d = (sel_q == SEL_LS);
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_IF;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
      err_q      <= err_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign ls_ack   = ls_ack_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DW, default 16, data/instruction word width.
REQ-002 Parameter AW, default 9, address width.
REQ-003 Parameter DEPTH, default 256, number of implemented memory words.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 if_req  input  1  instruction-fetch request; held with if_addr until if_ack.
REQ-007 if_addr  input  AW  fetch address.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse; rdata valid in the same cycle.
REQ-009 ls_req  input  1  load/store request; held with ls_we, ls_addr, ls_wdata until ls_ack.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr  input  AW  load/store address.
REQ-012 ls_wdata  input  DW  store data.
REQ-013 ls_ack  output  1  one-cycle load/store completion pulse.
REQ-014 rdata  output  DW  read data for the acked fetch or load; holds until next capture.
REQ-015 err  output  1  qualifies an ack: address out of range, access not performed.
REQ-016 mem_rw  output  1  memory command, 0 = read, 1 = write.
REQ-017 mem_addr  output  AW  memory address.
REQ-018 mem_din  output  DW  memory write data.
REQ-019 mem_dout  input  DW  memory read data, valid one edge after a read is sampled.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; all outputs SHALL be registered.
REQ-021 IDLE SHALL grant when any request is present and go to ISSUE, loading mem_addr, mem_rw (ls_we for a load/store grant, 0 for a fetch) and mem_din from the granted port.
REQ-022 With both requests present in IDLE, grant SHALL go to the port not granted last; the first contended grant after reset SHALL go to ls.
REQ-023 ISSUE SHALL last exactly one cycle; mem_rw SHALL be 0 in every state other than ISSUE.
REQ-024 From ISSUE, a write SHALL go to ACK and a read SHALL go to WAIT.
REQ-025 WAIT SHALL capture mem_dout into rdata and go to ACK.
REQ-026 In ACK the granted port's ack SHALL be 1 for exactly one cycle; the FSM then SHALL return to IDLE.
REQ-027 Latency from the grant edge to the ack cycle SHALL be two cycles for reads and one cycle for writes; requests SHALL NOT be sampled in ISSUE, WAIT or ACK.
REQ-028 An address with value >= DEPTH SHALL skip ISSUE and WAIT and go from IDLE directly to ACK with err = 1 and rdata = 0, and mem_rw SHALL stay 0.
REQ-029 err SHALL be 0 in every ack cycle for an in-range address and 0 outside ack cycles.
REQ-030 A store SHALL leave rdata unchanged.
REQ-031 A request deasserted before its ack is a protocol violation; the access in flight SHALL still complete and ack.

Reset
REQ-032 Asserting rst_n low SHALL force the FSM to IDLE, and mem_rw, if_ack, ls_ack and err to 0, and rdata, mem_addr and mem_din to 0 immediately, without waiting for a clock edge.
REQ-033 A reset asserted mid-access SHALL abort the access without an ack; a still-pending request SHALL be re-arbitrated on the first edge after release, with ls given priority.

Structure
REQ-034 Package mem_ctrl_pkg SHALL hold the DW, AW and DEPTH defaults, the FSM state enum and the port-select encoding.
REQ-035 Arbitration (REQ-022 plus the last-grant flop) SHALL be a sub-module mem_arb; the FSM and datapath SHALL stay in mem_ctrl.

Verification
REQ-036 Fetch: if_req=1 with if_addr=5 and mem[5]=16'hA0C0 -> if_ack in the second cycle after the grant, rdata=16'hA0C0, err=0.
REQ-037 Store then load: ls_we=1, ls_addr=20, ls_wdata=16'h1234 -> ls_ack one cycle after the grant with mem_rw high for exactly one cycle; then load from 20 -> rdata=16'h1234.
REQ-038 Contention: if_req and ls_req held together from reset -> grants ls, if, ls, if alternately with no lost request.
REQ-039 Out of range: ls_addr=9'h100 with ls_we=1 -> ls_ack with err=1, rdata=0, mem_rw never 1, memory unchanged.
REQ-040 Reset in ISSUE of a store -> mem_rw drops to 0 asynchronously, no ack, and the held request is re-issued after release.
